bank_rd_arb: RTL and testbench

BANK_RD_ARB -- requirements
Module: bank_rd_arb

---
 rtl/bank_rd_arb_pkg.sv | 31 +++
 rtl/bank_lane_pick.sv | 36 +++
 rtl/bank_rd_arb.sv | 271 +++++++++++++++++++++++++++
 tb/tb_bank_rd_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_rd_arb_pkg.sv
// Shared constants, FSM state type and helpers for the four-lane banked read arbiter.
package bank_rd_arb_pkg;

   localparam int DW     = 14;
   localparam int AW     = 9;
   localparam int NLANES = 4;
   localparam int NBANKS = 4;
   localparam int LW     = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

   // True when any two lanes of a packed index vector target the same bank.
   function automatic logic has_dup_idx(input logic [NLANES*LW-1:0] idx);
      logic dup;
      dup = 1'b0;
      for (int i = 0; i < NLANES; i++) begin
         for (int j = i + 1; j < NLANES; j++) begin
            if (idx[i*LW +: LW] == idx[j*LW +: LW]) begin
               dup = 1'b1;
            end else begin
               dup = dup;
            end
         end
      end
      return dup;
   endfunction

endpackage

// File: rtl/bank_lane_pick.sv
// Per-bank selector: lowest-numbered pending lane aimed at each bank, plus the resulting lane grant mask.
module bank_lane_pick
   import bank_rd_arb_pkg::*;
(
   input  logic [NLANES-1:0]    pend,
   input  logic [NLANES*LW-1:0] idx,
   output logic [NBANKS-1:0]    bank_hit,
   output logic [NBANKS*LW-1:0] bank_lane,
   output logic [NLANES-1:0]    lane_grant
);

   // Scan lanes high to low so the lowest matching lane wins.
   always_comb begin
      bank_hit   = {NBANKS{1'b0}};
      bank_lane  = {(NBANKS*LW){1'b0}};
      lane_grant = {NLANES{1'b0}};
      for (int b = 0; b < NBANKS; b++) begin
         for (int l = NLANES - 1; l >= 0; l--) begin
            if (pend[l] && (idx[l*LW +: LW] == LW'(b))) begin
               bank_hit[b]            = 1'b1;
               bank_lane[b*LW +: LW]  = LW'(l);
            end else begin
               bank_hit[b]            = bank_hit[b];
            end
         end
      end
      for (int b = 0; b < NBANKS; b++) begin
         if (bank_hit[b]) begin
            lane_grant[bank_lane[b*LW +: LW]] = 1'b1;
         end else begin
            lane_grant = lane_grant;
         end
      end
   end

endmodule

// File: rtl/bank_rd_arb.sv
// Four-lane read arbiter: issues lanes to their banks in conflict-free groups and reassembles the
// returned data in lane order, one response per accepted request.
module bank_rd_arb #(
   parameter int DW = bank_rd_arb_pkg::DW,
   parameter int AW = bank_rd_arb_pkg::AW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [1:0]    lane_idx0,
   input  logic [1:0]    lane_idx1,
   input  logic [1:0]    lane_idx2,
   input  logic [1:0]    lane_idx3,
   input  logic [AW-1:0] lane_add0,
   input  logic [AW-1:0] lane_add1,
   input  logic [AW-1:0] lane_add2,
   input  logic [AW-1:0] lane_add3,
   output logic          bank_ren0,
   output logic          bank_ren1,
   output logic          bank_ren2,
   output logic          bank_ren3,
   output logic [AW-1:0] bank_addr0,
   output logic [AW-1:0] bank_addr1,
   output logic [AW-1:0] bank_addr2,
   output logic [AW-1:0] bank_addr3,
   input  logic [DW-1:0] bank_rdata0,
   input  logic [DW-1:0] bank_rdata1,
   input  logic [DW-1:0] bank_rdata2,
   input  logic [DW-1:0] bank_rdata3,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data0,
   output logic [DW-1:0] rsp_data1,
   output logic [DW-1:0] rsp_data2,
   output logic [DW-1:0] rsp_data3,
   output logic          conflict,
   output logic [15:0]   conflict_cnt
);

   import bank_rd_arb_pkg::*;

   arb_state_t          state_r;
   arb_state_t          state_nxt_s;
   logic [NLANES-1:0]   pend_r;
   logic [NLANES*LW-1:0] idx_r;
   logic [AW-1:0]       add_r [NLANES];

   logic [NBANKS-1:0]   hit_s;
   logic [NBANKS*LW-1:0] bank_lane_s;
   logic [NLANES-1:0]   grant_s;
   logic                issue_s;
   logic                ready_s;
   logic                last_grp_s;
   logic                accept_s;
   logic                first_grp_s;

   logic [NBANKS-1:0]   ren_r;
   logic [AW-1:0]       addr_r [NBANKS];

   logic [NLANES-1:0]   t1_mask_r;
   logic [NLANES-1:0]   t2_mask_r;
   logic                t1_last_r;
   logic                t2_last_r;
   logic [NLANES*LW-1:0] t1_idx_r;
   logic [NLANES*LW-1:0] t2_idx_r;

   logic [DW-1:0]       rdata_s [NBANKS];
   logic [DW-1:0]       cap_s [NLANES];
   logic [DW-1:0]       hold_r [NLANES];
   logic [DW-1:0]       rsp_data_r [NLANES];
   logic                rsp_valid_r;
   logic                conflict_r;
   logic [15:0]         conflict_cnt_r;

   assign rdata_s[0] = bank_rdata0;
   assign rdata_s[1] = bank_rdata1;
   assign rdata_s[2] = bank_rdata2;
   assign rdata_s[3] = bank_rdata3;

   bank_lane_pick u_pick (
      .pend       (pend_r),
      .idx        (idx_r),
      .bank_hit   (hit_s),
      .bank_lane  (bank_lane_s),
      .lane_grant (grant_s)
   );

   assign last_grp_s  = issue_s && ((pend_r & ~grant_s) == {NLANES{1'b0}});
   assign accept_s    = req_valid && ready_s;
   assign first_grp_s = issue_s && (pend_r == {NLANES{1'b1}});

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next state: stay in ISSUE while lanes remain or a new request arrives.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (last_grp_s && !accept_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ISSUE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM outputs: a new request fits only once the current group drains pending.
   always_comb begin
      issue_s = 1'b0;
      ready_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            issue_s = 1'b0;
            ready_s = 1'b1;
         end
         ST_ISSUE: begin
            issue_s = 1'b1;
            ready_s = ((pend_r & ~grant_s) == {NLANES{1'b0}});
         end
         default: begin
            issue_s = 1'b0;
            ready_s = 1'b0;
         end
      endcase
   end

   // Request latch and pending-lane bookkeeping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_r <= {NLANES{1'b0}};
         idx_r  <= {(NLANES*LW){1'b0}};
         for (int l = 0; l < NLANES; l++) begin
            add_r[l] <= {AW{1'b0}};
         end
      end else if (accept_s) begin
         pend_r   <= {NLANES{1'b1}};
         idx_r    <= {lane_idx3, lane_idx2, lane_idx1, lane_idx0};
         add_r[0] <= lane_add0;
         add_r[1] <= lane_add1;
         add_r[2] <= lane_add2;
         add_r[3] <= lane_add3;
      end else if (issue_s) begin
         pend_r <= pend_r & ~grant_s;
      end else begin
         pend_r <= pend_r;
      end
   end

   // Bank command outputs; an idle bank keeps its last address.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ren_r <= {NBANKS{1'b0}};
         for (int b = 0; b < NBANKS; b++) begin
            addr_r[b] <= {AW{1'b0}};
         end
      end else begin
         ren_r <= hit_s & {NBANKS{issue_s}};
         for (int b = 0; b < NBANKS; b++) begin
            if (issue_s && hit_s[b]) begin
               addr_r[b] <= add_r[bank_lane_s[b*LW +: LW]];
            end else begin
               addr_r[b] <= addr_r[b];
            end
         end
      end
   end

   // Two-stage tracking of the issued group so capture lines up with the bank read latency.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         t1_mask_r <= {NLANES{1'b0}};
         t2_mask_r <= {NLANES{1'b0}};
         t1_last_r <= 1'b0;
         t2_last_r <= 1'b0;
         t1_idx_r  <= {(NLANES*LW){1'b0}};
         t2_idx_r  <= {(NLANES*LW){1'b0}};
      end else begin
         t1_mask_r <= grant_s & {NLANES{issue_s}};
         t1_last_r <= last_grp_s;
         t1_idx_r  <= idx_r;
         t2_mask_r <= t1_mask_r;
         t2_last_r <= t1_last_r;
         t2_idx_r  <= t1_idx_r;
      end
   end

   // Merge freshly returned lanes with those captured by earlier groups.
   always_comb begin
      for (int l = 0; l < NLANES; l++) begin
         cap_s[l] = hold_r[l];
         if (t2_mask_r[l]) begin
            cap_s[l] = rdata_s[t2_idx_r[l*LW +: LW]];
         end else begin
            cap_s[l] = hold_r[l];
         end
      end
   end

   // Holding registers and response output.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rsp_valid_r <= 1'b0;
         for (int l = 0; l < NLANES; l++) begin
            hold_r[l]     <= {DW{1'b0}};
            rsp_data_r[l] <= {DW{1'b0}};
         end
      end else begin
         rsp_valid_r <= t2_last_r;
         for (int l = 0; l < NLANES; l++) begin
            hold_r[l] <= cap_s[l];
            if (t2_last_r) begin
               rsp_data_r[l] <= cap_s[l];
            end else begin
               rsp_data_r[l] <= rsp_data_r[l];
            end
         end
      end
   end

   // Conflict pulse and saturating count, raised while the first group of a request issues.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         conflict_r     <= 1'b0;
         conflict_cnt_r <= 16'd0;
      end else if (first_grp_s && has_dup_idx(idx_r)) begin
         conflict_r <= 1'b1;
         if (conflict_cnt_r != 16'hFFFF) begin
            conflict_cnt_r <= conflict_cnt_r + 16'd1;
         end else begin
            conflict_cnt_r <= conflict_cnt_r;
         end
      end else begin
         conflict_r     <= 1'b0;
         conflict_cnt_r <= conflict_cnt_r;
      end
   end

   assign req_ready    = ready_s;
   assign bank_ren0    = ren_r[0];
   assign bank_ren1    = ren_r[1];
   assign bank_ren2    = ren_r[2];
   assign bank_ren3    = ren_r[3];
   assign bank_addr0   = addr_r[0];
   assign bank_addr1   = addr_r[1];
   assign bank_addr2   = addr_r[2];
   assign bank_addr3   = addr_r[3];
   assign rsp_valid    = rsp_valid_r;
   assign rsp_data0    = rsp_data_r[0];
   assign rsp_data1    = rsp_data_r[1];
   assign rsp_data2    = rsp_data_r[2];
   assign rsp_data3    = rsp_data_r[3];
   assign conflict     = conflict_r;
   assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_bank_rd_arb.sv
// Scoreboard bench for bank_rd_arb: a rank-based schedule model predicts bank commands, ready,
// conflict pulses and response data/timing; banks are modelled as synchronous memories (data = row+100).
module tb_bank_rd_arb;

   localparam int DW = 14;
   localparam int AW = 9;

   logic          clk;
   logic          rstn;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    lane_idx0, lane_idx1, lane_idx2, lane_idx3;
   logic [AW-1:0] lane_add0, lane_add1, lane_add2, lane_add3;
   logic          bank_ren0, bank_ren1, bank_ren2, bank_ren3;
   logic [AW-1:0] bank_addr0, bank_addr1, bank_addr2, bank_addr3;
   logic [DW-1:0] bank_rdata0, bank_rdata1, bank_rdata2, bank_rdata3;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data0, rsp_data1, rsp_data2, rsp_data3;
   logic          conflict;
   logic [15:0]   conflict_cnt;

   bank_rd_arb #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
      .lane_idx0(lane_idx0), .lane_idx1(lane_idx1), .lane_idx2(lane_idx2), .lane_idx3(lane_idx3),
      .lane_add0(lane_add0), .lane_add1(lane_add1), .lane_add2(lane_add2), .lane_add3(lane_add3),
      .bank_ren0(bank_ren0), .bank_ren1(bank_ren1), .bank_ren2(bank_ren2), .bank_ren3(bank_ren3),
      .bank_addr0(bank_addr0), .bank_addr1(bank_addr1), .bank_addr2(bank_addr2), .bank_addr3(bank_addr3),
      .bank_rdata0(bank_rdata0), .bank_rdata1(bank_rdata1), .bank_rdata2(bank_rdata2), .bank_rdata3(bank_rdata3),
      .rsp_valid(rsp_valid),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
      .conflict(conflict), .conflict_cnt(conflict_cnt)
   );

   typedef struct { logic [4*DW-1:0] data; int cyc; } rsp_t;
   typedef struct { int cyc; logic [15:0] cnt; } cf_t;

   rsp_t            rsp_q[$];
   cf_t             cf_q[$];
   logic [3:0]      ren_exp [int];
   logic [4*AW-1:0] addr_exp [int];
   int              cyc = 0;
   int              last_issue_edge = 0;
   int              model_cnt = 0;
   int              n_checks = 0;
   int              n_fail = 0;
   bit              mon_en = 1'b0;

   logic [3:0]      m_ren;
   logic [4*AW-1:0] m_addr;
   logic [4*AW-1:0] m_addr_act;
   rsp_t            m_rsp;
   cf_t             m_cf;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous bank memories: row r of any bank reads back r+100.
   always @(posedge clk) begin
      if (bank_ren0) bank_rdata0 <= DW'(bank_addr0) + 14'd100;
      if (bank_ren1) bank_rdata1 <= DW'(bank_addr1) + 14'd100;
      if (bank_ren2) bank_rdata2 <= DW'(bank_addr2) + 14'd100;
      if (bank_ren3) bank_rdata3 <= DW'(bank_addr3) + 14'd100;
   end

   function automatic void chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endfunction

   // Reference model: lane l goes out in group rank(l) = number of earlier lanes on the same bank.
   task automatic expect_req(input logic [7:0] idx, input logic [4*AW-1:0] add);
      int e0, g, e;
      int rank [4];
      logic [3:0]      tr;
      logic [4*AW-1:0] ta;
      logic [4*DW-1:0] d;
      logic [1:0]      b;
      e0 = cyc + 1;
      g  = 1;
      for (int l = 0; l < 4; l++) begin
         rank[l] = 0;
         for (int j = 0; j < l; j++) if (idx[j*2 +: 2] == idx[l*2 +: 2]) rank[l]++;
         if (rank[l] + 1 > g) g = rank[l] + 1;
      end
      for (int l = 0; l < 4; l++) begin
         e = e0 + 1 + rank[l];
         b = idx[l*2 +: 2];
         tr = ren_exp.exists(e) ? ren_exp[e] : 4'b0000;
         ta = addr_exp.exists(e) ? addr_exp[e] : '0;
         tr[b] = 1'b1;
         ta[b*AW +: AW] = add[l*AW +: AW];
         ren_exp[e]  = tr;
         addr_exp[e] = ta;
         d[l*DW +: DW] = DW'(add[l*AW +: AW]) + 14'd100;
      end
      rsp_q.push_back('{data: d, cyc: e0 + 2 + g});
      last_issue_edge = e0 + g;
      if (g > 1) begin
         if (model_cnt < 65535) model_cnt++;
         cf_q.push_back('{cyc: e0 + 1, cnt: 16'(model_cnt)});
      end
   endtask

   // Drive one request starting at a falling edge; hold it until accepted (bounded).
   task automatic send(input logic [7:0] idx, input logic [4*AW-1:0] add);
      bit done;
      done = 1'b0;
      {lane_idx3, lane_idx2, lane_idx1, lane_idx0} = idx;
      {lane_add3, lane_add2, lane_add1, lane_add0} = add;
      req_valid = 1'b1;
      for (int t = 0; t < 8 && !done; t++) begin
         #1;
         if (req_ready) begin
            expect_req(idx, add);
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (!done) chk("req_accept_timeout", 0, 1);
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && (rsp_q.size() != 0 || cf_q.size() != 0); t++) @(negedge clk);
      chk("drain_rsp_left", rsp_q.size(), 0);
      idle(2);
   endtask

   task automatic chk_all_zero();
      chk("rst_bank_ren", {bank_ren3, bank_ren2, bank_ren1, bank_ren0}, 0);
      chk("rst_bank_addr", {bank_addr3, bank_addr2, bank_addr1, bank_addr0}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", {rsp_data3, rsp_data2, rsp_data1, rsp_data0}, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
   endtask

   // Monitor: compares every DUT output against the scoreboard on each falling edge.
   always @(negedge clk) begin
      if (rstn && mon_en) begin
         chk("req_ready", req_ready, (cyc + 1 >= last_issue_edge));
         m_ren  = ren_exp.exists(cyc) ? ren_exp[cyc] : 4'b0000;
         m_addr = addr_exp.exists(cyc) ? addr_exp[cyc] : '0;
         m_addr_act = {bank_addr3, bank_addr2, bank_addr1, bank_addr0};
         chk("bank_ren", {bank_ren3, bank_ren2, bank_ren1, bank_ren0}, m_ren);
         for (int b = 0; b < 4; b++) begin
            if (m_ren[b]) chk("bank_addr", m_addr_act[b*AW +: AW], m_addr[b*AW +: AW]);
         end
         if (ren_exp.exists(cyc)) begin
            ren_exp.delete(cyc);
            addr_exp.delete(cyc);
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               m_rsp = rsp_q.pop_front();
               chk("rsp_cycle", cyc, m_rsp.cyc);
               chk("rsp_data", {rsp_data3, rsp_data2, rsp_data1, rsp_data0}, m_rsp.data);
            end
         end else if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
            chk("rsp_missing", 0, 1);
            m_rsp = rsp_q.pop_front();
         end
         if (conflict) begin
            if (cf_q.size() == 0) begin
               chk("conflict_unexpected", 1, 0);
            end else begin
               m_cf = cf_q.pop_front();
               chk("conflict_cycle", cyc, m_cf.cyc);
               chk("conflict_cnt", conflict_cnt, m_cf.cnt);
            end
         end else if (cf_q.size() != 0 && cf_q[0].cyc <= cyc) begin
            chk("conflict_missing", 0, 1);
            m_cf = cf_q.pop_front();
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]      ri;
      logic [4*AW-1:0] ra;
      rstn = 1'b1;
      req_valid = 1'b0;
      {lane_idx3, lane_idx2, lane_idx1, lane_idx0} = 8'd0;
      {lane_add3, lane_add2, lane_add1, lane_add0} = '0;
      {bank_rdata3, bank_rdata2, bank_rdata1, bank_rdata0} = '0;
      #2 rstn = 1'b0;
      #1 chk_all_zero();
      chk("rst_req_ready", req_ready, 1);
      @(negedge clk);
      @(negedge clk);
      #1 rstn = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Conflict-free single request.
      send({2'd3, 2'd2, 2'd1, 2'd0}, {9'd8, 9'd7, 9'd6, 9'd5});
      idle(6);

      // Eight back-to-back conflict-free requests (rotated bank maps).
      for (int i = 0; i < 8; i++) begin
         for (int l = 0; l < 4; l++) ri[l*2 +: 2] = 2'((l + i) % 4);
         for (int l = 0; l < 4; l++) ra[l*AW +: AW] = AW'($urandom_range(0, 511));
         send(ri, ra);
      end
      drain();

      // All lanes on bank 2, then a two-group split.
      send({2'd2, 2'd2, 2'd2, 2'd2}, {9'd4, 9'd3, 9'd2, 9'd1});
      drain();
      chk("conflict_cnt_after_all_same", conflict_cnt, 1);
      send({2'd1, 2'd1, 2'd0, 2'd0}, {9'd40, 9'd30, 9'd20, 9'd10});
      drain();

      // Randomised traffic, including duplicate rows within a bank.
      for (int n = 0; n < 300; n++) begin
         ri = 8'($urandom);
         for (int l = 0; l < 4; l++) ra[l*AW +: AW] = AW'($urandom_range(0, 511));
         if ($urandom_range(0, 7) == 0) ra[AW +: AW] = ra[0 +: AW];
         send(ri, ra);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      drain();

      // Reset one cycle after accepting an all-bank-3 request.
      send({2'd3, 2'd3, 2'd3, 2'd3}, {9'd11, 9'd12, 9'd13, 9'd14});
      @(posedge clk);
      #1 rstn = 1'b0;
      rsp_q.delete();
      cf_q.delete();
      ren_exp.delete();
      addr_exp.delete();
      last_issue_edge = 0;
      model_cnt = 0;
      #1 chk_all_zero();
      @(negedge clk);
      #1 rstn = 1'b1;
      chk("post_reset_req_ready", req_ready, 1);
      @(negedge clk);
      idle(10);

      // Counter saturation, preloaded close to the limit.
      #1 force dut.conflict_cnt_r = 16'd65531;
      model_cnt = 65531;
      #1 release dut.conflict_cnt_r;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         for (int l = 0; l < 4; l++) ra[l*AW +: AW] = AW'($urandom_range(0, 511));
         send({2'd2, 2'd1, 2'd0, 2'd0}, ra);
      end
      drain();
      chk("conflict_cnt_saturated", conflict_cnt, 65535);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
